// File: rtl/oric_mem_pkg.sv
// Shared types and default sizing for the Oric memory subsystem.
// The clear-state enum is used by the dpram_clr sweep sequencer.
package oric_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 8;
  localparam logic [DEF_DW-1:0] DEF_CLR_VAL = '1;

endpackage

// File: rtl/dpram_clr_seq.sv
// Clear sweep sequencer: walks every address once and emits a write strobe,
// address and fill value to the array; busy/done report sweep progress.
module dpram_clr_seq
  import oric_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter logic [DW-1:0] CLR_VAL = '1
) (
  input  logic          i_clk_sys,
  input  logic          i_reset,
  input  logic          i_clr_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data
);

  clr_state_t    r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  // Reset re-arms the sweep from address 0; start requests only count in IDLE.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_cnt == '1) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: begin
          r_done <= 1'b0;
          if (i_clr_start) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
      endcase
    end
  end

  // No array write happens in a reset cycle, even though the state is CLEAR.
  assign o_wr_en   = (r_state == CLEAR) && !i_reset;
  assign o_wr_addr = r_cnt;
  assign o_wr_data = CLR_VAL;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: rtl/dpram_clr.sv
// True dual-port synchronous RAM with optional hardware clear sweep.
// Define DPRAM_CLEAR_EN to build the sweep sequencer; otherwise clr_* are inert.
module dpram_clr
  import oric_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter logic [DW-1:0] CLR_VAL = '1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_d,
  input  logic          a_cs,
  input  logic          a_we,
  output logic [DW-1:0] a_q,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_d,
  input  logic          b_cs,
  input  logic          b_we,
  output logic [DW-1:0] b_q,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];

  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  logic [DW-1:0] w_clr_data;
  logic          w_port_wr_ok;

`ifdef DPRAM_CLEAR_EN
  dpram_clr_seq #(
    .AW      (AW),
    .DW      (DW),
    .CLR_VAL (CLR_VAL)
  ) u_seq (
    .i_clk_sys   (clk_sys),
    .i_reset     (reset),
    .i_clr_start (clr_start),
    .o_busy      (clr_busy),
    .o_done      (clr_done),
    .o_wr_en     (w_clr_we),
    .o_wr_addr   (w_clr_addr),
    .o_wr_data   (w_clr_data)
  );

  // Port writes are locked out for the whole sweep, and while reset re-arms it.
  assign w_port_wr_ok = !clr_busy && !reset;
`else
  logic w_unused_start;

  assign w_unused_start = clr_start;
  assign clr_busy       = 1'b0;
  assign clr_done       = 1'b0;
  assign w_clr_we       = 1'b0;
  assign w_clr_addr     = '0;
  assign w_clr_data     = CLR_VAL;
  assign w_port_wr_ok   = 1'b1;
`endif

  // Later assignments win: port B over port A, the sweep over both.
  always_ff @(posedge clk_sys) begin
    if (w_port_wr_ok && a_cs && a_we) r_mem[a_addr] <= a_d;
    if (w_port_wr_ok && b_cs && b_we) r_mem[b_addr] <= b_d;
    if (w_clr_we) r_mem[w_clr_addr] <= w_clr_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      a_q <= '0;
    end else if (a_cs) begin
      a_q <= r_mem[a_addr];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      b_q <= '0;
    end else if (b_cs) begin
      b_q <= r_mem[b_addr];
    end
  end

endmodule

// File: tb/tb_dpram_clr.sv
// Self-checking bench for dpram_clr (AW=4, DW=8, CLR_VAL=FF).
// Sweep scenarios are exercised only when DPRAM_CLEAR_EN is defined.
module tb_dpram_clr;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk_sys;
  logic          reset;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_d, b_d, a_q, b_q;
  logic          a_cs, a_we, b_cs, b_we;
  logic          clr_start, clr_busy, clr_done;

  int total = 0;
  int bad = 0;

  typedef struct {
    string         name;
    logic [DW-1:0] val;
  } exp_t;

  typedef struct {
    logic          acs, awe;
    logic [AW-1:0] aaddr;
    logic [DW-1:0] ad;
    logic          bcs, bwe;
    logic [AW-1:0] baddr;
    logic [DW-1:0] bd;
    logic          chka;
    logic [DW-1:0] expa;
    logic          chkb;
    logic [DW-1:0] expb;
  } vec_t;

  exp_t qA[$];
  exp_t qB[$];
  logic chkA = 1'b0;
  logic chkB = 1'b0;
  vec_t vecs[13];

  dpram_clr #(
    .AW      (AW),
    .DW      (DW),
    .CLR_VAL (8'hFF)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .a_addr    (a_addr),
    .a_d       (a_d),
    .a_cs      (a_cs),
    .a_we      (a_we),
    .a_q       (a_q),
    .b_addr    (b_addr),
    .b_d       (b_d),
    .b_cs      (b_cs),
    .b_we      (b_we),
    .b_q       (b_q),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic portsIdle();
    a_cs = 1'b0; a_we = 1'b0;
    b_cs = 1'b0; b_we = 1'b0;
  endtask

  // Advance one edge; read data queued for this edge is compared 1 ns later.
  task automatic tick();
    logic ca, cb;
    exp_t e;
    ca = chkA;
    cb = chkB;
    @(posedge clk_sys);
    #1;
    chkA = 1'b0;
    chkB = 1'b0;
    if (ca) begin
      e = qA.pop_front();
      checkOutput(e.name, a_q, e.val);
    end
    if (cb) begin
      e = qB.pop_front();
      checkOutput(e.name, b_q, e.val);
    end
  endtask

  task automatic readA(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
    a_cs = 1'b1; a_we = 1'b0; a_addr = addr;
    qA.push_back('{name, exp});
    chkA = 1'b1;
  endtask

  task automatic readB(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
    b_cs = 1'b1; b_we = 1'b0; b_addr = addr;
    qB.push_back('{name, exp});
    chkB = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    a_cs = v.acs; a_we = v.awe; a_addr = v.aaddr; a_d = v.ad;
    b_cs = v.bcs; b_we = v.bwe; b_addr = v.baddr; b_d = v.bd;
    if (v.chka) qA.push_back('{$sformatf("vec%0d_a", idx), v.expa});
    if (v.chkb) qB.push_back('{$sformatf("vec%0d_b", idx), v.expb});
    chkA = v.chka;
    chkB = v.chkb;
    tick();
  endtask

  // Called with busy already seen high; len counts cycles busy reads 1.
  task automatic measureSweep(input int pokeAt, input int pulseAt, output int len, output int dones);
    logic finished;
    finished = 1'b0;
    len = 1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (len == pokeAt) begin
        a_cs = 1'b1; a_we = 1'b1; a_addr = 4'd0; a_d = 8'h33;
        b_cs = 1'b1; b_we = 1'b1; b_addr = 4'd5; b_d = 8'h44;
      end
      if (len == pulseAt) clr_start = 1'b1;
      tick();
      if (len == pulseAt) clr_start = 1'b0;
      portsIdle();
      if (clr_done) dones++;
      if (!clr_busy) begin
        finished = 1'b1;
        break;
      end
      len++;
    end
    if (!finished) checkBit("sweep_timeout", clr_busy, 1'b0);
  endtask

  initial begin
    int len, dones, predones;

    vecs[0]  = '{1, 1, 4'd3,  8'h5A, 0, 0, 4'd0,  8'h00, 0, 8'h00, 0, 8'h00};
    vecs[1]  = '{1, 0, 4'd3,  8'h00, 0, 0, 4'd0,  8'h00, 1, 8'h5A, 0, 8'h00};
    vecs[2]  = '{1, 1, 4'd3,  8'h11, 1, 0, 4'd3,  8'h00, 1, 8'h5A, 1, 8'h5A};
    vecs[3]  = '{1, 0, 4'd3,  8'h00, 1, 0, 4'd3,  8'h00, 1, 8'h11, 1, 8'h11};
    vecs[4]  = '{1, 1, 4'd7,  8'hAA, 1, 1, 4'd7,  8'hBB, 0, 8'h00, 0, 8'h00};
    vecs[5]  = '{1, 0, 4'd7,  8'h00, 1, 0, 4'd7,  8'h00, 1, 8'hBB, 1, 8'hBB};
    vecs[6]  = '{1, 1, 4'd0,  8'h01, 1, 1, 4'd1,  8'h02, 0, 8'h00, 0, 8'h00};
    vecs[7]  = '{1, 0, 4'd1,  8'h00, 1, 0, 4'd0,  8'h00, 1, 8'h02, 1, 8'h01};
    vecs[8]  = '{0, 0, 4'd9,  8'h00, 0, 0, 4'd9,  8'h00, 1, 8'h02, 1, 8'h01};
    vecs[9]  = '{1, 0, 4'd3,  8'h00, 1, 1, 4'd3,  8'h77, 1, 8'h11, 0, 8'h00};
    vecs[10] = '{1, 0, 4'd3,  8'h00, 1, 0, 4'd3,  8'h00, 1, 8'h77, 1, 8'h77};
    vecs[11] = '{1, 1, 4'd15, 8'h9C, 0, 0, 4'd15, 8'h00, 0, 8'h00, 0, 8'h00};
    vecs[12] = '{1, 0, 4'd15, 8'h00, 1, 0, 4'd15, 8'h00, 1, 8'h9C, 1, 8'h9C};

    reset = 1'b1;
    clr_start = 1'b0;
    a_addr = '0; b_addr = '0; a_d = '0; b_d = '0;
    portsIdle();

`ifdef DPRAM_CLEAR_EN
    $display("[TB] power-up sweep");
    tick();
    checkOutput("rst_a_q", a_q, 8'h00);
    checkOutput("rst_b_q", b_q, 8'h00);
    checkBit("rst_busy", clr_busy, 1'b1);
    checkBit("rst_done", clr_done, 1'b0);
    reset = 1'b0;
    measureSweep(-1, -1, len, dones);
    checkInt("init_busy_len", len, DEPTH);
    checkInt("init_done_cnt", dones, 1);
    for (int i = 0; i < DEPTH; i++) begin
      readA(AW'(i), 8'hFF, $sformatf("init_a%0d", i));
      readB(AW'(DEPTH - 1 - i), 8'hFF, $sformatf("init_b%0d", DEPTH - 1 - i));
      tick();
      if (i == 0) checkBit("done_one_cycle", clr_done, 1'b0);
    end
    portsIdle();
`else
    $display("[TB] clear disabled build");
    a_cs = 1'b1; a_we = 1'b1; a_addr = 4'd4; a_d = 8'h3C;
    tick();
    portsIdle();
    checkOutput("rst_a_q", a_q, 8'h00);
    checkOutput("rst_b_q", b_q, 8'h00);
    checkBit("rst_busy", clr_busy, 1'b0);
    checkBit("rst_done", clr_done, 1'b0);
    reset = 1'b0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    checkBit("start_ignored_busy", clr_busy, 1'b0);
    readA(4'd4, 8'h3C, "write_in_reset");
    tick();
    portsIdle();
`endif

    $display("[TB] port vectors");
    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);
    portsIdle();
    tick();

`ifdef DPRAM_CLEAR_EN
    $display("[TB] requested sweep with blocked writes");
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    checkBit("start_busy", clr_busy, 1'b1);
    measureSweep(10, -1, len, dones);
    checkInt("req_busy_len", len, DEPTH);
    checkInt("req_done_cnt", dones, 1);
    a_cs = 1'b1; a_we = 1'b1; a_addr = 4'd9; a_d = 8'h66;
    tick();
    readA(4'd0, 8'hFF, "blocked_a_write");
    readB(4'd5, 8'hFF, "blocked_b_write");
    tick();
    portsIdle();
    readA(4'd9, 8'h66, "first_idle_write");
    tick();
    portsIdle();

    $display("[TB] reset mid-sweep");
    a_cs = 1'b1; a_we = 1'b1; a_addr = 4'd12; a_d = 8'h12;
    tick();
    portsIdle();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    predones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (clr_done) predones++;
    end
    checkBit("mid_busy", clr_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkBit("mid_rst_busy", clr_busy, 1'b1);
    checkBit("mid_rst_done", clr_done, 1'b0);
    measureSweep(-1, -1, len, dones);
    checkInt("restart_busy_len", len, DEPTH);
    checkInt("restart_done_cnt", predones + dones, 1);
    readA(4'd12, 8'hFF, "restart_cleared");
    tick();
    portsIdle();

    $display("[TB] back-to-back sweeps");
    clr_start = 1'b1;
    tick();
    measureSweep(-1, -1, len, dones);
    checkInt("b2b_first_len", len, DEPTH);
    checkInt("b2b_first_done", dones, 1);
    tick();
    clr_start = 1'b0;
    checkBit("b2b_restart_busy", clr_busy, 1'b1);
    checkBit("b2b_restart_done", clr_done, 1'b0);
    measureSweep(-1, 5, len, dones);
    checkInt("b2b_second_len", len, DEPTH);
    checkInt("b2b_second_done", dones, 1);
    tick();
    checkBit("b2b_idle_busy", clr_busy, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
